// File: rtl/mem_pkg.sv
// Shared encodings for the RAM store path: request sizes, store FSM states and address widths.
package mem_pkg;

    localparam int ADDR_W_DEF = 32;
    localparam int RAM_AW     = ADDR_W_DEF - 2;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READ,
        ST_MERGE,
        ST_WRITE,
        ST_FAULT
    } state_e;

endpackage

// File: rtl/store_unit_if.sv
// Store request handshake plus the shared RAM port, seen from the store master and from its environment.
interface store_unit_if
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_data;
    logic [1:0]        req_size;
    logic              done;
    logic              err;
    logic [ADDR_W-3:0] ram_addr;
    logic [31:0]       ram_din;
    logic              ram_re;
    logic              ram_we;
    logic [31:0]       ram_dout;

    modport master (
        input  req_valid, req_addr, req_data, req_size, ram_dout,
        output req_ready, done, err, ram_addr, ram_din, ram_re, ram_we
    );

    modport slave (
        output req_valid, req_addr, req_data, req_size, ram_dout,
        input  req_ready, done, err, ram_addr, ram_din, ram_re, ram_we
    );
endinterface

// File: rtl/store_merge.sv
// Combinational lane merge of a byte/half/word store into an old little-endian RAM word.
module store_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] st_data_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    output logic [31:0] merged_o
);
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SIZE_BYTE: merged_o[{lane_i, 3'b000} +: 8] = st_data_i[7:0];
            SIZE_HALF: begin
                if (lane_i[1]) merged_o[31:16] = st_data_i[15:0];
                else           merged_o[15:0]  = st_data_i[15:0];
            end
            SIZE_WORD: merged_o = st_data_i;
            default:   merged_o = old_word_i;
        endcase
    end
endmodule

// File: rtl/store_unit.sv
// RAM store master: word store done 1 cycle after accept, byte/half read-modify-write in 2, faults in 1.
// req_ready is high only in IDLE, so a held request waits until the current store finishes.
module store_unit
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    store_unit_if.master bus
);
    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       data_q, data_d;
    logic [1:0]        size_q, size_d;
    logic [31:0]       merged;

    store_merge u_merge (
        .old_word_i (bus.ram_dout),
        .st_data_i  (data_q),
        .size_i     (size_q),
        .lane_i     (addr_q[1:0]),
        .merged_o   (merged)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            data_q  <= '0;
            size_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            size_q  <= size_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        data_d        = data_q;
        size_d        = size_q;
        bus.req_ready = 1'b0;
        bus.done      = 1'b0;
        bus.err       = 1'b0;
        bus.ram_re    = 1'b0;
        bus.ram_we    = 1'b0;
        bus.ram_din   = '0;
        bus.ram_addr  = (state_q == ST_IDLE) ? '0 : addr_q[ADDR_W-1:2];

        case (state_q)
            ST_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) begin
                    addr_d = bus.req_addr;
                    data_d = bus.req_data;
                    size_d = bus.req_size;
                    if (bus.req_size == SIZE_WORD && bus.req_addr[1:0] == 2'b00)
                        state_d = ST_WRITE;
                    else if (bus.req_size == SIZE_BYTE ||
                             (bus.req_size == SIZE_HALF && !bus.req_addr[0]))
                        state_d = ST_READ;
                    else
                        state_d = ST_FAULT;
                end
            end
            ST_READ: begin
                bus.ram_re = 1'b1;
                state_d    = ST_MERGE;
            end
            // ram_dout carries the word fetched in READ; write it back merged in the same cycle.
            ST_MERGE: begin
                bus.ram_we  = 1'b1;
                bus.ram_din = merged;
                bus.done    = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_WRITE: begin
                bus.ram_we  = 1'b1;
                bus.ram_din = data_q;
                bus.done    = 1'b1;
                state_d     = ST_IDLE;
            end
            ST_FAULT: begin
                bus.done = 1'b1;
                bus.err  = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit with a small 1-cycle-latency RAM model.
module tb_store_unit;
    import mem_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;
    int   wr_cnt   = 0;
    int   overlap  = 0;
    logic [31:0] mem [16];

    store_unit_if #(.ADDR_W(32)) bus ();

    store_unit #(.ADDR_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.ram_re && bus.ram_we) overlap <= overlap + 1;
        if (bus.ram_re) bus.ram_dout <= mem[bus.ram_addr[3:0]];
        if (bus.ram_we) begin
            mem[bus.ram_addr[3:0]] <= bus.ram_din;
            wr_cnt <= wr_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for a single accept edge, then clears the fields.
    task automatic issue(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
        bus.req_valid = 1'b1;
        bus.req_addr  = addr;
        bus.req_data  = data;
        bus.req_size  = size;
        tick();
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
    endtask

    task automatic word_store(input logic [31:0] addr, input logic [31:0] data, input string tag);
        issue(addr, data, SIZE_WORD);
        check({tag, " we"},   {31'd0, bus.ram_we}, 32'd1);
        check({tag, " addr"}, {2'b00, bus.ram_addr}, addr >> 2);
        check({tag, " din"},  bus.ram_din, data);
        check({tag, " done"}, {31'd0, bus.done}, 32'd1);
        tick();
    endtask

    task automatic rmw_store(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size,
                             input logic [31:0] exp_din, input string tag);
        issue(addr, data, size);
        check({tag, " re"},    {31'd0, bus.ram_re}, 32'd1);
        check({tag, " raddr"}, {2'b00, bus.ram_addr}, addr >> 2);
        check({tag, " ready"}, {31'd0, bus.req_ready}, 32'd0);
        tick();
        check({tag, " we"},    {31'd0, bus.ram_we}, 32'd1);
        check({tag, " din"},   bus.ram_din, exp_din);
        check({tag, " done"},  {31'd0, bus.done}, 32'd1);
        tick();
    endtask

    initial begin
        int wr_before;
        logic [31:0] fa_addr [3];
        logic [1:0]  fa_size [3];
        fa_addr[0] = 32'h02; fa_size[0] = SIZE_WORD;
        fa_addr[1] = 32'h03; fa_size[1] = SIZE_HALF;
        fa_addr[2] = 32'h08; fa_size[2] = SIZE_RSVD;

        reset         = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_data  = '0;
        bus.req_size  = '0;
        #1;
        check("rst ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst done",  {31'd0, bus.done}, 32'd0);
        check("rst err",   {31'd0, bus.err}, 32'd0);
        check("rst re_we", {30'd0, bus.ram_re, bus.ram_we}, 32'd0);
        check("rst addr",  {2'b00, bus.ram_addr}, 32'd0);
        check("rst din",   bus.ram_din, 32'd0);
        tick();
        tick();
        reset = 1'b0;
        tick();

        issue(32'h10, 32'hDEADBEEF, SIZE_WORD);
        check("w1 we",    {31'd0, bus.ram_we}, 32'd1);
        check("w1 addr",  {2'b00, bus.ram_addr}, 32'd4);
        check("w1 din",   bus.ram_din, 32'hDEADBEEF);
        check("w1 done",  {31'd0, bus.done}, 32'd1);
        check("w1 err",   {31'd0, bus.err}, 32'd0);
        check("w1 ready", {31'd0, bus.req_ready}, 32'd0);
        tick();
        check("w1 idle done", {31'd0, bus.done}, 32'd0);
        check("w1 mem", mem[4], 32'hDEADBEEF);

        word_store(32'h04, 32'h11223344, "pre1");
        rmw_store(32'h06, 32'h000000AA, SIZE_BYTE, 32'h11AA3344, "b06");
        check("b06 mem", mem[1], 32'h11AA3344);
        word_store(32'h04, 32'h11223344, "pre2");
        rmw_store(32'h06, 32'h0000BEEF, SIZE_HALF, 32'hBEEF3344, "h06");
        word_store(32'h04, 32'h11223344, "pre3");
        rmw_store(32'h04, 32'h0000BEEF, SIZE_HALF, 32'h1122BEEF, "h04");
        check("h04 mem", mem[1], 32'h1122BEEF);

        wr_before = wr_cnt;
        for (int i = 0; i < 3; i++) begin
            issue(fa_addr[i], 32'h12345678, fa_size[i]);
            check($sformatf("fault%0d done", i), {31'd0, bus.done}, 32'd1);
            check($sformatf("fault%0d err", i),  {31'd0, bus.err}, 32'd1);
            check($sformatf("fault%0d re_we", i), {30'd0, bus.ram_re, bus.ram_we}, 32'd0);
            tick();
            check($sformatf("fault%0d clear", i), {31'd0, bus.done}, 32'd0);
        end
        check("fault writes", wr_cnt, wr_before);
        check("fault mem1", mem[1], 32'h1122BEEF);

        word_store(32'h08, 32'hA5A5A5A5, "pre4");
        bus.req_valid = 1'b1;
        bus.req_addr  = 32'h09;
        bus.req_data  = 32'h0000003C;
        bus.req_size  = SIZE_BYTE;
        tick();
        bus.req_addr  = 32'h0C;
        bus.req_data  = 32'hCAFEF00D;
        bus.req_size  = SIZE_WORD;
        check("b2b read ready", {31'd0, bus.req_ready}, 32'd0);
        check("b2b read re",    {31'd0, bus.ram_re}, 32'd1);
        tick();
        check("b2b merge ready", {31'd0, bus.req_ready}, 32'd0);
        check("b2b merge din",   bus.ram_din, 32'hA5A53CA5);
        tick();
        check("b2b idle ready",  {31'd0, bus.req_ready}, 32'd1);
        tick();
        bus.req_valid = 1'b0;
        check("b2b w we",   {31'd0, bus.ram_we}, 32'd1);
        check("b2b w addr", {2'b00, bus.ram_addr}, 32'd3);
        check("b2b w din",  bus.ram_din, 32'hCAFEF00D);
        tick();
        check("b2b mem2", mem[2], 32'hA5A53CA5);
        check("b2b mem3", mem[3], 32'hCAFEF00D);

        wr_before = wr_cnt;
        issue(32'h05, 32'h00000077, SIZE_BYTE);
        check("rstmid re", {31'd0, bus.ram_re}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rstmid re_we", {30'd0, bus.ram_re, bus.ram_we}, 32'd0);
        check("rstmid done",  {31'd0, bus.done}, 32'd0);
        check("rstmid ready", {31'd0, bus.req_ready}, 32'd1);
        tick();
        reset = 1'b0;
        tick();
        tick();
        check("rstmid ready after", {31'd0, bus.req_ready}, 32'd1);
        check("rstmid writes", wr_cnt, wr_before);
        check("rstmid mem1", mem[1], 32'h1122BEEF);
        check("no re/we overlap", overlap, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
